key_expand: RTL and testbench

KEY_EXPAND -- requirements
Module: key_expand

---
 rtl/key_expand_pkg.sv | 50 +++++
 rtl/key_expand_round.sv | 28 ++
 rtl/key_expand.sv | 73 +++++++
 tb/tb_key_expand.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_expand_pkg.sv
// Shared AES-128 sizing constants and byte/word/S-box helpers for the key schedule.
package key_expand_pkg;

  localparam int BYTE_S = 8;
  localparam int WORD_S = 32;
  localparam int KEY_S  = 128;
  localparam int BLK_S  = 128;
  localparam int NK     = 4;
  localparam int NR     = 10;

  localparam logic [3:0] NR_IDX    = 4'(NR);
  localparam logic [7:0] RCON_SEED = 8'h01;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [BYTE_S-1:0] get_sbox(input logic [BYTE_S-1:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [BYTE_S-1:0] get_byte(input logic [WORD_S-1:0] w, input int i);
    return w[i*BYTE_S +: BYTE_S];
  endfunction

  function automatic logic [WORD_S-1:0] get_word(input logic [KEY_S-1:0] k, input int i);
    return k[i*WORD_S +: WORD_S];
  endfunction

  // Multiply by x in GF(2^8); wraps 0x80 to 0x1b.
  function automatic logic [BYTE_S-1:0] xtime(input logic [BYTE_S-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_expand_round.sv
// One AES-128 key-schedule step: derives round key r+1 from round key r and its rcon.
module key_expand_round
  import key_expand_pkg::*;
(
  input  logic [KEY_S-1:0]  prev_key,
  input  logic [BYTE_S-1:0] rcon,
  output logic [KEY_S-1:0]  next_key
);

  logic [WORD_S-1:0] w3;
  logic [WORD_S-1:0] rot;
  logic [WORD_S-1:0] t;
  logic [WORD_S-1:0] n0, n1, n2, n3;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w3  = get_word(prev_key, 3);
    rot = {get_byte(w3, 0), get_byte(w3, 3), get_byte(w3, 2), get_byte(w3, 1)};
    t   = {get_sbox(get_byte(rot, 3)), get_sbox(get_byte(rot, 2)),
           get_sbox(get_byte(rot, 1)), get_sbox(get_byte(rot, 0)) ^ rcon};
    n0  = get_word(prev_key, 0) ^ t;
    n1  = get_word(prev_key, 1) ^ n0;
    n2  = get_word(prev_key, 2) ^ n1;
    n3  = w3 ^ n2;
    next_key = {n3, n2, n1, n0};
  end

endmodule

// File: rtl/key_expand.sv
// AES-128 key expansion: iterative schedule build into a register array with indexed read-out.
module key_expand
  import key_expand_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [KEY_S-1:0]  key_in,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [NK-1:0]     round_key_no,
  output logic [KEY_S-1:0]  round_key,
  output logic              keys_valid
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [BYTE_S-1:0] rcon;
  logic [KEY_S-1:0]  sched [NR+1];
  logic [KEY_S-1:0]  prev_key;
  logic [KEY_S-1:0]  next_key;

  assign key_ready = (state != ST_EXPAND);
  assign prev_key  = (cnt == 4'd0) ? '0 : sched[cnt - 4'd1];

  key_expand_round u_round (
    .prev_key (prev_key),
    .rcon     (rcon),
    .next_key (next_key)
  );

  // NOTE: the schedule array is cleared on reset so an aborted expansion never leaks old keys.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      rcon       <= RCON_SEED;
      keys_valid <= 1'b0;
      round_key  <= '0;
      for (int i = 0; i <= NR; i++) sched[i] <= '0;
    end else begin
      // NOTE: non-blocking writes mean this read sees the schedule from before any same-edge update.
      round_key <= (round_key_no > NR_IDX) ? '0 : sched[round_key_no];

      case (state)
        ST_IDLE, ST_DONE: begin
          if (key_valid) begin
            sched[0]   <= key_in;
            rcon       <= RCON_SEED;
            cnt        <= 4'd1;
            keys_valid <= 1'b0;
            state      <= ST_EXPAND;
          end
        end
        ST_EXPAND: begin
          sched[cnt] <= next_key;
          rcon       <= xtime(rcon);
          if (cnt == NR_IDX) begin
            state      <= ST_DONE;
            keys_valid <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand against an independent byte-oriented key-schedule model.
module tb_key_expand;

  logic         clk;
  logic         reset_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [3:0]   round_key_no;
  logic [127:0] round_key;
  logic         keys_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox_ref [256];
  logic [127:0] exp_sched [11];

  key_expand dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .round_key_no (round_key_no),
    .round_key    (round_key),
    .keys_valid   (keys_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [7:0] w [176];
    logic [7:0] tmp [4];
    logic [7:0] t0;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = key[8*i +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
      if (i % 4 == 0) begin
        t0 = tmp[0];
        tmp[0] = sbox_ref[tmp[1]] ^ rc;
        tmp[1] = sbox_ref[tmp[2]];
        tmp[2] = sbox_ref[tmp[3]];
        tmp[3] = sbox_ref[t0];
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
    end
    for (int r = 0; r < 11; r++)
      for (int i = 0; i < 16; i++) exp_sched[r][8*i +: 8] = w[16*r + i];
  endtask

  // FIPS-197 text order (first byte leftmost) to the port layout (byte 0 at [7:0]).
  function automatic logic [127:0] fips(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[127 - 8*i -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [127:0] key);
    key_in    = key;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
  endtask

  // Returns edges counted after acceptance until keys_valid rises (bounded).
  task automatic wait_done(input string name, output int edges);
    edges = 0;
    while (!keys_valid && edges < 20) begin
      step();
      edges++;
    end
    n_cmp++;
    if (edges !== 10) begin
      n_err++;
      $display("FAIL %s done_latency: got %0d edges, expected 10", name, edges);
    end
  endtask

  task automatic read_all(input string name);
    round_key_no = 4'd0;
    step();
    for (int i = 1; i <= 11; i++) begin
      n_cmp++;
      if (round_key !== exp_sched[i-1]) begin
        n_err++;
        $display("FAIL %s idx%0d: got %h expected %h", name, i-1, round_key, exp_sched[i-1]);
      end
      if (i <= 10) begin
        round_key_no = 4'(i);
        step();
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; key_valid = 1'b0; key_in = '0; round_key_no = 4'd0;
    #12;
    n_cmp++;
    if (round_key !== '0 || keys_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got rk=%h kv=%b expected 0/0", round_key, keys_valid);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    n_cmp++;
    if (key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_key_ready: got %b expected 1", key_ready);
    end
    n_cmp++;
    if (round_key !== '0) begin
      n_err++;
      $display("FAIL reset_sched0: got %h expected 0", round_key);
    end
  endtask

  task automatic test_fips();
    int edges;
    logic [127:0] k = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    model(k);
    accept(k);
    n_cmp++;
    if (keys_valid !== 1'b0 || key_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fips_expand_flags: got kv=%b kr=%b expected 0/0", keys_valid, key_ready);
    end
    wait_done("fips", edges);
    read_all("fips_model");
    round_key_no = 4'd1; step();
    n_cmp++;
    if (round_key !== fips(128'ha0fafe1788542cb123a339392a6c7605)) begin
      n_err++;
      $display("FAIL fips_idx1: got %h", round_key);
    end
    round_key_no = 4'd10; step();
    n_cmp++;
    if (round_key !== fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin
      n_err++;
      $display("FAIL fips_idx10: got %h", round_key);
    end
  endtask

  task automatic test_ignore_busy();
    int edges;
    logic [127:0] a = rand_key();
    logic [127:0] b = rand_key();
    model(a);
    accept(a);
    step(); step();
    for (int p = 0; p < 2; p++) begin
      key_in = b; key_valid = 1'b1;
      n_cmp++;
      if (key_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_key_ready pulse%0d: got %b expected 0", p, key_ready);
      end
      step();
      key_valid = 1'b0;
      if (p == 0) step();
    end
    edges = 5;
    while (!keys_valid && edges < 20) begin step(); edges++; end
    n_cmp++;
    if (edges !== 10) begin
      n_err++;
      $display("FAIL busy_done_latency: got %0d expected 10", edges);
    end
    read_all("busy_sched");
  endtask

  task automatic test_restart_in_done();
    int edges;
    logic [127:0] old0 = exp_sched[0];
    round_key_no = 4'd0;
    model(128'h0);
    accept(128'h0);
    n_cmp++;
    if (keys_valid !== 1'b0) begin
      n_err++;
      $display("FAIL restart_kv_fall: got %b expected 0", keys_valid);
    end
    n_cmp++;
    if (round_key !== old0) begin
      n_err++;
      $display("FAIL restart_read_pre_accept: got %h expected %h", round_key, old0);
    end
    wait_done("restart", edges);
    round_key_no = 4'd10; step();
    n_cmp++;
    if (round_key !== fips(128'hb4ef5bcb3e92e21123e951cf6f8f188e)) begin
      n_err++;
      $display("FAIL zero_key_idx10: got %h", round_key);
    end
    read_all("zero_sched");
  endtask

  task automatic test_out_of_range();
    logic [3:0] idx [4] = '{4'd11, 4'd15, 4'd12, 4'd13};
    for (int i = 0; i < 4; i++) begin
      round_key_no = 4'd5; step();
      round_key_no = idx[i]; step();
      n_cmp++;
      if (round_key !== '0) begin
        n_err++;
        $display("FAIL out_of_range idx%0d: got %h expected 0", idx[i], round_key);
      end
    end
  endtask

  task automatic test_reset_mid();
    accept(rand_key());
    round_key_no = 4'd0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (round_key !== '0 || keys_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_async: got rk=%h kv=%b kr=%b expected 0/0/1", round_key, keys_valid, key_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 11; i++) exp_sched[i] = '0;
    read_all("reset_mid_sched");
    n_cmp++;
    if (keys_valid !== 1'b0 || key_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_after: got kv=%b kr=%b expected 0/1", keys_valid, key_ready);
    end
  endtask

  task automatic test_random_keys();
    int edges;
    for (int n = 0; n < 4; n++) begin
      logic [127:0] k = rand_key();
      model(k);
      accept(k);
      wait_done("random", edges);
      read_all("random_sched");
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_ignore_busy();
    test_restart_in_done();
    test_out_of_range();
    test_reset_mid();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
